// File: rtl/joy_db9_scan_pkg.sv
// Shared types and width helpers for the DB9 joystick serial scanner.
package joy_db9_pkg;

   // Scanner sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_CLKHI  = 3'd3,
      ST_DONE   = 3'd4
   } scan_state_e;

   localparam int unsigned STATE_W = 3;

   // Bits needed for a counter running 0..n-1 (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/joy_db9_scan_if.sv
// DB9 chain and middleboard reflection signals.
interface joy_db9_scan_if;
   logic JOY_CLK;
   logic JOY_LOAD;
   logic JOY_DATA;
   logic JOY_XCLK;
   logic JOY_XLOAD;
   logic JOY_XDATA;

   modport master (
      output JOY_CLK, JOY_LOAD, JOY_XDATA,
      input  JOY_DATA, JOY_XCLK, JOY_XLOAD
   );

   modport slave (
      input  JOY_CLK, JOY_LOAD, JOY_XDATA,
      output JOY_DATA, JOY_XCLK, JOY_XLOAD
   );
endinterface

// File: rtl/joy_db9_scan_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module joy_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta_q;
   logic sync_q;

   // Metastability chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/joy_db9_scan.sv
// DB9 joystick chain scanner with middleboard reflection and pass-through.
module joy_db9_scan
   import joy_db9_pkg::*;
#(
   parameter int unsigned NUM_JOY    = 2,
   parameter int unsigned JOY_BITS   = 12,
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned SCAN_GAP   = 64,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                        clk_sys,
   input  logic                        reset,
   input  logic                        refl_en,
   joy_db9_scan_if.master              db9,
   output logic [NUM_JOY*JOY_BITS-1:0] joy_out,
   output logic                        scan_done
);
   localparam int unsigned N     = NUM_JOY * JOY_BITS;
   localparam int unsigned IDX_W = cnt_w(N);
   localparam int unsigned GAP_W = cnt_w(SCAN_GAP);
   localparam int unsigned DIV_W = cnt_w(CLK_DIV);
   localparam logic [N-1:0] INV_MASK = {N{ACTIVE_LOW}};
   localparam logic [N-1:0] TOP_ONE  = N'(1) << (N - 1);

   scan_state_e state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N-1:0]     shift_q, shift_d;
   logic [N-1:0]     raw_q, raw_d;
   logic [N-1:0]     joy_out_q, joy_out_d;
   logic [N-1:0]     refl_q, refl_d;
   logic             scan_done_q, scan_done_d;
   logic             joy_clk_q, joy_clk_d;
   logic             joy_load_q, joy_load_d;
   logic             xclk_prev_q, xclk_prev_d;
   logic             tick_c;
   logic             xclk_s;
   logic             xload_s;

   joy_sync2 #(.RST_VAL(1'b1)) u_sync_xclk (
      .clk (clk_sys),
      .rst (reset),
      .d   (db9.JOY_XCLK),
      .q   (xclk_s)
   );

   joy_sync2 #(.RST_VAL(1'b1)) u_sync_xload (
      .clk (clk_sys),
      .rst (reset),
      .d   (db9.JOY_XLOAD),
      .q   (xload_s)
   );

   // Free-running serial tick divider.
   always_comb begin
      tick_c = (div_q == DIV_W'(CLK_DIV - 1));
      div_d  = tick_c ? '0 : div_q + DIV_W'(1);
   end

   // Scanner state register.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; pass-through mode pins the scanner in IDLE.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      if (refl_en) begin
         state_d = ST_IDLE;
         gap_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tick_c) begin
                  if (gap_q == GAP_W'(SCAN_GAP - 1)) begin
                     gap_d   = '0;
                     state_d = ST_LOAD;
                  end else begin
                     gap_d = gap_q + GAP_W'(1);
                  end
               end
            end
            ST_LOAD: begin
               if (tick_c) begin
                  idx_d   = '0;
                  state_d = ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (tick_c) begin
                  state_d = ST_CLKHI;
               end
            end
            ST_CLKHI: begin
               if (tick_c) begin
                  if (idx_q == IDX_W'(N - 1)) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = ST_SAMPLE;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output/datapath logic; results publish on the edge that enters DONE.
   always_comb begin
      shift_d     = shift_q;
      raw_d       = raw_q;
      joy_out_d   = joy_out_q;
      scan_done_d = 1'b0;
      if (!refl_en && (state_q == ST_SAMPLE) && tick_c) begin
         shift_d[idx_q] = db9.JOY_DATA;
      end
      if (state_d == ST_DONE) begin
         raw_d       = shift_d;
         joy_out_d   = shift_d ^ INV_MASK;
         scan_done_d = 1'b1;
      end
      joy_load_d = (state_d != ST_LOAD);
      joy_clk_d  = (state_d != ST_CLKHI);
   end

   // Reflection shifter: a load beats a coincident clock edge.
   always_comb begin
      xclk_prev_d = xclk_s;
      refl_d      = refl_q;
      if (!xload_s) begin
         refl_d = raw_q;
      end else if (xclk_s && !xclk_prev_q) begin
         refl_d = (refl_q >> 1) | TOP_ONE;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         div_q       <= '0;
         gap_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         raw_q       <= INV_MASK;
         joy_out_q   <= '0;
         scan_done_q <= 1'b0;
         joy_clk_q   <= 1'b1;
         joy_load_q  <= 1'b1;
         refl_q      <= '1;
         xclk_prev_q <= 1'b1;
      end else begin
         div_q       <= div_d;
         gap_q       <= gap_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         raw_q       <= raw_d;
         joy_out_q   <= joy_out_d;
         scan_done_q <= scan_done_d;
         joy_clk_q   <= joy_clk_d;
         joy_load_q  <= joy_load_d;
         refl_q      <= refl_d;
         xclk_prev_q <= xclk_prev_d;
      end
   end

   assign db9.JOY_CLK   = refl_en ? db9.JOY_XCLK  : joy_clk_q;
   assign db9.JOY_LOAD  = refl_en ? db9.JOY_XLOAD : joy_load_q;
   assign db9.JOY_XDATA = refl_en ? db9.JOY_DATA  : refl_q[0];
   assign joy_out       = joy_out_q;
   assign scan_done     = scan_done_q;
endmodule

// File: tb/tb_joy_db9_scan.sv
// Directed bench: two scanners (active-low and active-high) on modelled '165 chains.
`timescale 1ns/1ps
module tb_joy_db9_scan;
   localparam int unsigned N = 24;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   logic refl_en = 1'b0;
   logic xclk    = 1'b0;
   logic xload   = 1'b1;
   logic pt_mode = 1'b0;
   logic pt_data = 1'b1;
   logic [N-1:0] pat_a = 24'hFFFFFE;
   logic [N-1:0] pat_b = 24'h800001;
   logic [N-1:0] sr_a;
   logic [N-1:0] sr_b;
   logic [N-1:0] joy_out_a;
   logic [N-1:0] joy_out_b;
   logic         scan_done_a;
   logic         scan_done_b;
   int total = 0;
   int bad   = 0;

   joy_db9_scan_if if_a ();
   joy_db9_scan_if if_b ();

   assign if_a.JOY_XCLK  = xclk;
   assign if_a.JOY_XLOAD = xload;
   assign if_a.JOY_DATA  = pt_mode ? pt_data : sr_a[0];
   assign if_b.JOY_XCLK  = xclk;
   assign if_b.JOY_XLOAD = xload;
   assign if_b.JOY_DATA  = sr_b[0];

   joy_db9_scan #(.NUM_JOY(2), .JOY_BITS(12), .CLK_DIV(4), .SCAN_GAP(2), .ACTIVE_LOW(1'b1)) dut_a (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .refl_en   (refl_en),
      .db9       (if_a),
      .joy_out   (joy_out_a),
      .scan_done (scan_done_a)
   );

   joy_db9_scan #(.NUM_JOY(2), .JOY_BITS(12), .CLK_DIV(4), .SCAN_GAP(2), .ACTIVE_LOW(1'b0)) dut_b (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .refl_en   (refl_en),
      .db9       (if_b),
      .joy_out   (joy_out_b),
      .scan_done (scan_done_b)
   );

   always #5 clk_sys = ~clk_sys;

   // 24-bit parallel-in/serial-out chains: load while low, shift toward bit 0 on rising clock.
   always @(posedge if_a.JOY_CLK or negedge if_a.JOY_LOAD)
      if (!if_a.JOY_LOAD) sr_a <= pat_a;
      else                sr_a <= {1'b1, sr_a[N-1:1]};

   always @(posedge if_b.JOY_CLK or negedge if_b.JOY_LOAD)
      if (!if_b.JOY_LOAD) sr_b <= pat_b;
      else                sr_b <= {1'b1, sr_b[N-1:1]};

   task automatic xpulse();
      xclk = 1'b1;
      repeat (4) @(posedge clk_sys);
      xclk = 1'b0;
      repeat (4) @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_sys);
      #1;
      total++; if (if_a.JOY_CLK !== 1'b1) begin bad++; $display("FAIL reset_joy_clk got=%b exp=1", if_a.JOY_CLK); end
      total++; if (if_a.JOY_LOAD !== 1'b1) begin bad++; $display("FAIL reset_joy_load got=%b exp=1", if_a.JOY_LOAD); end
      total++; if (if_a.JOY_XDATA !== 1'b1) begin bad++; $display("FAIL reset_xdata got=%b exp=1", if_a.JOY_XDATA); end
      total++; if (joy_out_a !== 24'h0 || joy_out_b !== 24'h0) begin bad++; $display("FAIL reset_joy_out got=%h/%h exp=0", joy_out_a, joy_out_b); end
      total++; if (scan_done_a !== 1'b0) begin bad++; $display("FAIL reset_scan_done got=%b exp=0", scan_done_a); end
   endtask

   task automatic test_scan();
      int   falls = 0;
      logic prev  = 1'b1;
      reset = 1'b0;
      for (int i = 1; i <= 204; i++) begin
         @(posedge clk_sys);
         #1;
         if (prev && !if_a.JOY_CLK) falls++;
         prev = if_a.JOY_CLK;
         total++; if (if_a.JOY_LOAD !== ((i >= 8 && i <= 11) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL scan_load cyc=%0d got=%b", i, if_a.JOY_LOAD); end
         total++; if (scan_done_a !== (i == 204) || scan_done_b !== (i == 204)) begin bad++; $display("FAIL scan_done cyc=%0d got=%b/%b exp=%b", i, scan_done_a, scan_done_b, (i == 204)); end
         if (i < 204) begin
            total++; if (joy_out_a !== 24'h0 || joy_out_b !== 24'h0) begin bad++; $display("FAIL scan_partial cyc=%0d got=%h/%h exp=0", i, joy_out_a, joy_out_b); end
         end
      end
      total++; if (falls != 24) begin bad++; $display("FAIL scan_clk_count got=%0d exp=24", falls); end
      total++; if (joy_out_a !== 24'h000001) begin bad++; $display("FAIL scan_active_low got=%h exp=000001", joy_out_a); end
      total++; if (joy_out_b !== 24'h800001) begin bad++; $display("FAIL scan_active_high got=%h exp=800001", joy_out_b); end
      @(posedge clk_sys);
      #1;
      total++; if (scan_done_a !== 1'b0) begin bad++; $display("FAIL scan_pulse_width got=%b exp=0", scan_done_a); end
      total++; if (joy_out_a !== 24'h000001) begin bad++; $display("FAIL scan_hold got=%h exp=000001", joy_out_a); end
   endtask

   task automatic test_reset_mid_scan();
      int   falls = 0;
      logic prev  = 1'b1;
      bit   hit   = 1'b0;
      for (int i = 0; i < 600 && !hit; i++) begin
         @(posedge clk_sys);
         #1;
         if (prev && !if_a.JOY_CLK) falls++;
         prev = if_a.JOY_CLK;
         if (falls == 11) hit = 1'b1;
      end
      total++; if (!hit) begin bad++; $display("FAIL mid_wait timeout falls=%0d exp=11", falls); end
      #2 reset = 1'b1;
      #1;
      total++; if (if_a.JOY_CLK !== 1'b1) begin bad++; $display("FAIL mid_joy_clk got=%b exp=1", if_a.JOY_CLK); end
      total++; if (if_a.JOY_LOAD !== 1'b1) begin bad++; $display("FAIL mid_joy_load got=%b exp=1", if_a.JOY_LOAD); end
      total++; if (if_a.JOY_XDATA !== 1'b1) begin bad++; $display("FAIL mid_xdata got=%b exp=1", if_a.JOY_XDATA); end
      total++; if (joy_out_a !== 24'h0 || joy_out_b !== 24'h0) begin bad++; $display("FAIL mid_joy_out got=%h/%h exp=0", joy_out_a, joy_out_b); end
      total++; if (scan_done_a !== 1'b0) begin bad++; $display("FAIL mid_scan_done got=%b exp=0", scan_done_a); end
      repeat (3) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      for (int i = 1; i <= 204; i++) begin
         @(posedge clk_sys);
         #1;
         total++; if (if_a.JOY_LOAD !== ((i >= 8 && i <= 11) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL mid_gap_load cyc=%0d got=%b", i, if_a.JOY_LOAD); end
         total++; if (scan_done_a !== (i == 204)) begin bad++; $display("FAIL mid_done cyc=%0d got=%b exp=%b", i, scan_done_a, (i == 204)); end
         if (i < 204) begin
            total++; if (joy_out_a !== 24'h0) begin bad++; $display("FAIL mid_joy_out_held cyc=%0d got=%h exp=0", i, joy_out_a); end
         end
      end
      total++; if (joy_out_a !== 24'h000001) begin bad++; $display("FAIL mid_rescan got=%h exp=000001", joy_out_a); end
   endtask

   task automatic test_reflection();
      logic [N-1:0] model = 24'hFFFFFE;
      xload = 1'b0;
      repeat (4) @(posedge clk_sys);
      #1;
      total++; if (if_a.JOY_XDATA !== model[0]) begin bad++; $display("FAIL refl_load got=%b exp=%b", if_a.JOY_XDATA, model[0]); end
      xload = 1'b1;
      repeat (4) @(posedge clk_sys);
      #1;
      total++; if (if_a.JOY_XDATA !== model[0]) begin bad++; $display("FAIL refl_release got=%b exp=%b", if_a.JOY_XDATA, model[0]); end
      for (int p = 1; p <= 26; p++) begin
         xpulse();
         model = {1'b1, model[N-1:1]};
         total++; if (if_a.JOY_XDATA !== model[0]) begin bad++; $display("FAIL refl_shift pulse=%0d got=%b exp=%b", p, if_a.JOY_XDATA, model[0]); end
      end
   endtask

   task automatic test_load_wins();
      xload = 1'b0;
      xclk  = 1'b1;
      @(posedge clk_sys);
      #1;
      xload = 1'b1;
      repeat (4) @(posedge clk_sys);
      #1;
      total++; if (if_a.JOY_XDATA !== 1'b0) begin bad++; $display("FAIL load_wins_bit0 got=%b exp=0", if_a.JOY_XDATA); end
      xclk = 1'b0;
      repeat (4) @(posedge clk_sys);
      xpulse();
      total++; if (if_a.JOY_XDATA !== 1'b1) begin bad++; $display("FAIL load_wins_bit1 got=%b exp=1", if_a.JOY_XDATA); end
   endtask

   task automatic test_refl_hold_on_done();
      bit hit = 1'b0;
      xload = 1'b0;
      repeat (4) @(posedge clk_sys);
      xload = 1'b1;
      repeat (4) @(posedge clk_sys);
      #1;
      total++; if (if_a.JOY_XDATA !== 1'b0) begin bad++; $display("FAIL hold_bit0 got=%b exp=0", if_a.JOY_XDATA); end
      xpulse();
      total++; if (if_a.JOY_XDATA !== 1'b1) begin bad++; $display("FAIL hold_bit1 got=%b exp=1", if_a.JOY_XDATA); end
      pat_a = 24'h000000;
      for (int i = 0; i < 700 && !hit; i++) begin
         @(posedge clk_sys);
         #1;
         if (scan_done_a === 1'b1 && joy_out_a === 24'hFFFFFF) hit = 1'b1;
      end
      total++; if (!hit) begin bad++; $display("FAIL hold_wait timeout joy_out=%h exp=ffffff", joy_out_a); end
      total++; if (if_a.JOY_XDATA !== 1'b1) begin bad++; $display("FAIL hold_after_done got=%b exp=1", if_a.JOY_XDATA); end
      xpulse();
      total++; if (if_a.JOY_XDATA !== 1'b1) begin bad++; $display("FAIL hold_bit2 got=%b exp=1", if_a.JOY_XDATA); end
      xload = 1'b0;
      repeat (4) @(posedge clk_sys);
      xload = 1'b1;
      repeat (4) @(posedge clk_sys);
      #1;
      total++; if (if_a.JOY_XDATA !== 1'b0) begin bad++; $display("FAIL hold_reload_bit0 got=%b exp=0", if_a.JOY_XDATA); end
      xpulse();
      total++; if (if_a.JOY_XDATA !== 1'b0) begin bad++; $display("FAIL hold_reload_bit1 got=%b exp=0", if_a.JOY_XDATA); end
   endtask

   task automatic test_passthrough();
      logic [2:0] vb;
      pt_mode = 1'b1;
      refl_en = 1'b1;
      for (int v = 0; v < 8; v++) begin
         @(negedge clk_sys);
         vb      = 3'(v);
         xclk    = vb[0];
         xload   = vb[1];
         pt_data = vb[2];
         #1;
         total++; if (if_a.JOY_CLK !== vb[0]) begin bad++; $display("FAIL pt_clk v=%0d got=%b exp=%b", v, if_a.JOY_CLK, vb[0]); end
         total++; if (if_a.JOY_LOAD !== vb[1]) begin bad++; $display("FAIL pt_load v=%0d got=%b exp=%b", v, if_a.JOY_LOAD, vb[1]); end
         total++; if (if_a.JOY_XDATA !== vb[2]) begin bad++; $display("FAIL pt_xdata v=%0d got=%b exp=%b", v, if_a.JOY_XDATA, vb[2]); end
      end
      xclk    = 1'b0;
      xload   = 1'b1;
      pt_data = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk_sys);
         #1;
         total++; if (scan_done_a !== 1'b0 || joy_out_a !== 24'hFFFFFF) begin bad++; $display("FAIL pt_hold cyc=%0d done=%b joy_out=%h exp=0/ffffff", i, scan_done_a, joy_out_a); end
      end
      refl_en = 1'b0;
      pt_mode = 1'b0;
   endtask

   task automatic test_abort();
      int   falls = 0;
      int   lat   = 0;
      logic prev  = 1'b1;
      bit   hit   = 1'b0;
      pat_a = 24'hFFF000;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(posedge clk_sys);
         #1;
         if (prev && !if_a.JOY_CLK) falls++;
         prev = if_a.JOY_CLK;
         if (falls == 5) hit = 1'b1;
      end
      total++; if (!hit) begin bad++; $display("FAIL abort_wait timeout falls=%0d exp=5", falls); end
      refl_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_sys);
         #1;
         total++; if (scan_done_a !== 1'b0 || joy_out_a !== 24'hFFFFFF) begin bad++; $display("FAIL abort_hold cyc=%0d done=%b joy_out=%h exp=0/ffffff", i, scan_done_a, joy_out_a); end
      end
      refl_en = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(posedge clk_sys);
         #1;
         total++; if (scan_done_a !== 1'b0) begin bad++; $display("FAIL abort_no_done cyc=%0d got=%b exp=0", i, scan_done_a); end
         if (if_a.JOY_LOAD === 1'b0) hit = 1'b1;
      end
      total++; if (!hit) begin bad++; $display("FAIL abort_load timeout got=%b exp=0", if_a.JOY_LOAD); end
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(posedge clk_sys);
         #1;
         lat++;
         if (scan_done_a === 1'b1) hit = 1'b1;
      end
      total++; if (!hit || lat != 196) begin bad++; $display("FAIL abort_latency got=%0d exp=196", lat); end
      total++; if (joy_out_a !== 24'h000FFF) begin bad++; $display("FAIL abort_rescan got=%h exp=000fff", joy_out_a); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_reset_mid_scan();
      test_reflection();
      test_load_wins();
      test_refl_hold_on_done();
      test_passthrough();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/joy_db9_scan.md
JOY_DB9_SCAN -- requirements
Module: joy_db9_scan

Interface
REQ-001 SHALL have parameter NUM_JOY, default 2, number of joysticks on the serial chain (1..4).
REQ-002 SHALL have parameter JOY_BITS, default 12, bits per joystick.
REQ-003 SHALL have parameter CLK_DIV, default 16, clk_sys cycles per serial tick (>=2).
REQ-004 SHALL have parameter SCAN_GAP, default 64, idle ticks between scans.
REQ-005 SHALL have parameter ACTIVE_LOW, default 1; 1 means chain bits are low when pressed.
REQ-006 SHALL have port clk_sys, input, 1, the only clock, on which all logic is synchronous.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port refl_en, input, 1; 1 selects legacy pass-through mode.
REQ-009 SHALL have port JOY_CLK, output, 1, shift clock to the DB9 chain.
REQ-010 SHALL have port JOY_LOAD, output, 1, parallel load to the chain, active low.
REQ-011 SHALL have port JOY_DATA, input, 1, serial data from the chain.
REQ-012 SHALL have port JOY_XCLK, input, 1, middleboard reflection clock (asynchronous).
REQ-013 SHALL have port JOY_XLOAD, input, 1, middleboard reflection load, active low (asynchronous).
REQ-014 SHALL have port JOY_XDATA, output, 1, reflection serial data.
REQ-015 SHALL have port joy_out, output, NUM_JOY*JOY_BITS, active-high button state; bit k is the k-th bit sampled, and joystick j occupies [j*JOY_BITS +: JOY_BITS].
REQ-016 SHALL have port scan_done, output, 1, a one-cycle pulse when joy_out updates.

Function
REQ-017 Tick SHALL be a free-running divider that pulses once every CLK_DIV clk_sys cycles; all scanner state changes SHALL occur only on a tick.
REQ-018 Scanner FSM SHALL have states IDLE, LOAD, SAMPLE, CLKHI and DONE.
REQ-019 IDLE: JOY_LOAD=1 and JOY_CLK=1; after SCAN_GAP ticks the FSM SHALL go to LOAD.
REQ-020 LOAD: JOY_LOAD=0 for exactly one tick, then the FSM SHALL go to SAMPLE with bit index 0.
REQ-021 SAMPLE: on the tick, the FSM SHALL capture JOY_DATA into shift bit [index], drive JOY_CLK=0, and go to CLKHI.
REQ-022 CLKHI: JOY_CLK=1 (rising edge advances the chain), then index+1; if index=N-1 (N=NUM_JOY*JOY_BITS) the FSM SHALL go to DONE, else to SAMPLE.
REQ-023 DONE: in one clk_sys cycle (no tick wait), the FSM SHALL set joy_out = shift XOR {N{ACTIVE_LOW}}, pulse scan_done, and go to IDLE.
REQ-024 scan_done SHALL occur exactly (1+2*N)*CLK_DIV clk_sys cycles after JOY_LOAD falls.
REQ-025 joy_out SHALL hold its value between DONE events and never show a partial scan.
REQ-026 JOY_XCLK and JOY_XLOAD SHALL each be synchronised through 2 flops before use.
REQ-027 Reflection (refl_en=0): a synchronised JOY_XLOAD low SHALL load a reflection register from the latched raw (un-inverted) scan; each synchronised JOY_XCLK rising edge SHALL shift it toward bit 0; JOY_XDATA SHALL be reflection bit 0, and 1 after all N bits are shifted out.
REQ-028 If JOY_XLOAD is low on the same cycle as a JOY_XCLK rising edge, load SHALL win.
REQ-029 If DONE occurs during a reflection transfer, the reflection register SHALL be unchanged until the next JOY_XLOAD.
REQ-030 Pass-through (refl_en=1): JOY_CLK=JOY_XCLK, JOY_LOAD=JOY_XLOAD and JOY_XDATA=JOY_DATA combinationally; the scanner SHALL be held in IDLE and joy_out SHALL be held.
REQ-031 A refl_en change mid-scan SHALL abort the scan to IDLE without a DONE.

Reset
REQ-032 While reset=1: JOY_CLK=1, JOY_LOAD=1, JOY_XDATA=1, joy_out=0, scan_done=0, FSM=IDLE, gap/index/divider=0, reflection register all ones.
REQ-033 Reset mid-scan SHALL discard the partial shift data; the first scan after release SHALL start after SCAN_GAP ticks.

Structure
REQ-034 Package joy_db9_pkg SHALL hold the FSM state enum and width helper constants.
REQ-035 The block SHALL use one sub-module, joy_sync2 (2-flop synchroniser), instantiated for JOY_XCLK and JOY_XLOAD.

Verification (NUM_JOY=2, JOY_BITS=12, CLK_DIV=4, SCAN_GAP=2)
REQ-036 The bench SHALL model the chain as a 24-bit '165 holding 0xFFFFFE -> joy_out=0x000001 and scan_done 196 cycles after JOY_LOAD falls.
REQ-037 The bench SHALL run ACTIVE_LOW=0 with chain 0x800001 -> joy_out=0x800001.
REQ-038 The bench SHALL assert reset at scan bit 10 -> all outputs take their reset values immediately, no scan_done, and joy_out=0 until the next full scan.
REQ-039 The bench SHALL toggle JOY_XLOAD low then apply 24 JOY_XCLK pulses after a 0xFFFFFE scan -> JOY_XDATA sequence is 0,1,1,...,1, then stays 1.
REQ-040 With refl_en=1, the bench SHALL drive JOY_XCLK/JOY_XLOAD/JOY_DATA patterns -> JOY_CLK/JOY_LOAD/JOY_XDATA mirror them in the same cycle and joy_out does not change.
REQ-041 The bench SHALL raise JOY_XLOAD low coincident with a JOY_XCLK rise -> the register loads and bit 0 is not skipped.
